// File: rtl/uc_cycle_ctrl.sv
// Instruction-cycle sequencer: one-hot phase enables, run/halt/step control, post-reset hold and
// retire counter. Optional PC breakpoint compare is built when UC_CYCLE_CTRL_BKPT_EN is defined.
module uc_cycle_ctrl #(
  parameter int unsigned PC_W         = 11,
  parameter int unsigned STEP_W       = 8,
  parameter int unsigned RESET_HOLD   = 4,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_req_i,
  input  logic              halt_req_i,
  input  logic              step_req_i,
  input  logic [STEP_W-1:0] step_count_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              skip_i,
`ifdef UC_CYCLE_CTRL_BKPT_EN
  input  logic [PC_W-1:0]   bkpt_addr_i,
  input  logic              bkpt_valid_i,
  output logic              bkpt_hit_o,
`endif
  output logic [3:0]        ph_en_o,
  output logic              core_rst_o,
  output logic              halted_o,
  output logic              running_o,
  output logic              inst_retired_o,
  output logic [15:0]       retire_cnt_o
);

  typedef enum logic [1:0] {StHold, StHalt, StRun, StStep} state_e;

  state_e            state_q, state_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [1:0]        phase_q, phase_d;
  logic              core_rst_q, core_rst_d;
  logic [15:0]       retire_cnt_q, retire_cnt_d;
  logic              skip_pend_q, skip_pend_d;
  logic [STEP_W-1:0] step_left_q, step_left_d;
  logic              halt_pend_q, halt_pend_d;
  logic              running, boundary, step_done;

`ifdef UC_CYCLE_CTRL_BKPT_EN
  logic bkpt_pend_q, bkpt_pend_d;
  logic bkpt_hit_q, bkpt_hit_d;
  assign bkpt_hit_o = bkpt_hit_q;
`else
  logic unused_pc;
  assign unused_pc = ^pc_i;
`endif

  assign running        = (state_q == StRun) || (state_q == StStep);
  assign boundary       = running && (phase_q == 2'd3);
  assign ph_en_o        = running ? (4'b0001 << phase_q) : 4'b0000;
  assign inst_retired_o = boundary && !skip_pend_q;
  assign core_rst_o     = core_rst_q;
  assign halted_o       = (state_q == StHalt);
  assign running_o      = running;
  assign retire_cnt_o   = retire_cnt_q;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    phase_d      = phase_q;
    core_rst_d   = core_rst_q;
    retire_cnt_d = retire_cnt_q;
    skip_pend_d  = skip_pend_q;
    step_left_d  = step_left_q;
    halt_pend_d  = halt_pend_q;
    step_done    = 1'b0;
`ifdef UC_CYCLE_CTRL_BKPT_EN
    bkpt_pend_d  = bkpt_pend_q;
    bkpt_hit_d   = bkpt_hit_q;
`endif
    unique case (state_q)
      StHold: begin
        phase_d = 2'd0;
        if (hold_cnt_q == 4'd0) begin
          state_d    = START_HALTED ? StHalt : StRun;
          core_rst_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      StHalt: begin
        phase_d = 2'd0;
        // halt_req outranks run/step, so a simultaneous request leaves us halted
        if (!halt_req_i) begin
          if (run_req_i) begin
            state_d = StRun;
`ifdef UC_CYCLE_CTRL_BKPT_EN
            bkpt_hit_d = 1'b0;
`endif
          end else if (step_req_i) begin
            state_d     = StStep;
            step_left_d = (step_count_i == '0) ? STEP_W'(1) : step_count_i;
`ifdef UC_CYCLE_CTRL_BKPT_EN
            bkpt_hit_d = 1'b0;
`endif
          end
        end
      end
      StRun, StStep: begin
        phase_d = phase_q + 2'd1;
        if (halt_req_i) halt_pend_d = 1'b1;
`ifdef UC_CYCLE_CTRL_BKPT_EN
        if ((phase_q == 2'd0) && bkpt_valid_i && (pc_i == bkpt_addr_i)) begin
          halt_pend_d = 1'b1;
          bkpt_pend_d = 1'b1;
        end
`endif
        if (boundary) begin
          skip_pend_d = skip_i;
          if (!skip_pend_q) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
            if ((state_q == StStep) && (step_left_q != '0)) step_left_d = step_left_q - 1'b1;
          end
          // A skip raised by the last stepped instruction still plays out its skipped slot
          step_done = (state_q == StStep) && (step_left_d == '0) && !skip_i;
          if (halt_pend_q || halt_req_i || step_done) begin
            state_d     = StHalt;
            halt_pend_d = 1'b0;
`ifdef UC_CYCLE_CTRL_BKPT_EN
            if (bkpt_pend_q) begin
              bkpt_hit_d  = 1'b1;
              bkpt_pend_d = 1'b0;
            end
`endif
          end
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StHold;
      hold_cnt_q   <= 4'(RESET_HOLD);
      phase_q      <= 2'd0;
      core_rst_q   <= 1'b1;
      retire_cnt_q <= 16'd0;
      skip_pend_q  <= 1'b0;
      step_left_q  <= '0;
      halt_pend_q  <= 1'b0;
`ifdef UC_CYCLE_CTRL_BKPT_EN
      bkpt_pend_q  <= 1'b0;
      bkpt_hit_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      phase_q      <= phase_d;
      core_rst_q   <= core_rst_d;
      retire_cnt_q <= retire_cnt_d;
      skip_pend_q  <= skip_pend_d;
      step_left_q  <= step_left_d;
      halt_pend_q  <= halt_pend_d;
`ifdef UC_CYCLE_CTRL_BKPT_EN
      bkpt_pend_q  <= bkpt_pend_d;
      bkpt_hit_q   <= bkpt_hit_d;
`endif
    end
  end

endmodule
